// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer: state encoding,
// BCD digit limit, default prescale ratio and the load-digit clamp.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX             = 4'd9;
  localparam int         TICK_CYCLES_DEFAULT = 50_000_000;

  // Out-of-range load digits saturate to 9 so the outputs stay valid BCD.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// Free-running cycle counter with clear and enable; asserts tick on the last
// enabled cycle of each TICK_CYCLES-long period.
module tick_prescaler #(
  parameter int TICK_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  // Gated by enable so a paused counter sitting at LAST does not fire.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: loads 00-99, decrements once per prescaled
// tick, pulses Expired on reaching 00 and holds there until the next load.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  input  logic       Enable,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Expired
);

  state_t     state;
  logic       tick;
  logic       count_en;
  logic [3:0] load_tens;
  logic [3:0] load_ones;

  assign load_tens = clamp_bcd(LoadTens);
  assign load_ones = clamp_bcd(LoadOnes);
  assign count_en  = Enable && (state == ST_RUN);

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk    (Clock),
    .reset  (Reset),
    .clear  (Load),
    .enable (count_en),
    .tick   (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      Tens    <= 4'd0;
      Ones    <= 4'd0;
      Running <= 1'b0;
      Expired <= 1'b0;
    end else begin
      Expired <= 1'b0;
      // Load has priority over a coincident tick: no decrement is applied.
      if (Load) begin
        Tens <= load_tens;
        Ones <= load_ones;
        if (load_tens == 4'd0 && load_ones == 4'd0) begin
          state   <= ST_DONE;
          Running <= 1'b0;
          Expired <= 1'b1;
        end else begin
          state   <= ST_RUN;
          Running <= 1'b1;
        end
      end else if (tick) begin
        if (Ones != 4'd0) begin
          Ones <= Ones - 4'd1;
        end else begin
          Ones <= BCD_MAX;
          Tens <= Tens - 4'd1;
        end
        // 01 is the last value counted from; the borrow path never sees 00.
        if (Tens == 4'd0 && Ones == 4'd1) begin
          state   <= ST_DONE;
          Running <= 1'b0;
          Expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random
// load/enable/reset traffic against an integer-valued countdown model.
module tb_bcd_countdown_timer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       enable = 1'b1;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .TICK_CYCLES (TICK)
  ) dut (
    .Clock    (clk),
    .Reset    (reset),
    .Load     (load),
    .LoadTens (load_tens),
    .LoadOnes (load_ones),
    .Enable   (enable),
    .Tens     (tens),
    .Ones     (ones),
    .Running  (running),
    .Expired  (expired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining seconds as an integer plus enabled cycles into the step.
  int m_val   = 0;
  int m_phase = 0;
  bit m_run   = 1'b0;
  bit m_exp   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int t;
    int o;
    m_exp = 1'b0;
    if (reset) begin
      m_val = 0; m_phase = 0; m_run = 1'b0;
    end else if (load) begin
      t = (load_tens > 9) ? 9 : int'(load_tens);
      o = (load_ones > 9) ? 9 : int'(load_ones);
      m_val   = t * 10 + o;
      m_phase = 0;
      m_run   = (m_val != 0);
      m_exp   = (m_val == 0);
    end else if (m_run && enable) begin
      m_phase++;
      if (m_phase == TICK) begin
        m_phase = 0;
        m_val--;
        if (m_val == 0) begin
          m_run = 1'b0;
          m_exp = 1'b1;
        end
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tens",    32'(tens),    32'(m_val / 10));
    check("ones",    32'(ones),    32'(m_val % 10));
    check("running", 32'(running), 32'(m_run));
    check("expired", 32'(expired), 32'(m_exp));
  endtask

  task automatic run(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    tick_cycle();
    load = 1'b0;
  endtask

  // Counts edges until Expired is seen; a missing pulse is itself a failure.
  task automatic wait_expired(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick_cycle();
      n++;
      if (expired === 1'b1) break;
    end
    if (expired !== 1'b1) check("expire_timeout", 32'(expired), 32'd1);
  endtask

  int lat;

  initial begin
    // Reset, then idle.
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(20);

    // Full countdown from 12.
    enable = 1'b1;
    do_load(4'd1, 4'd2);
    check("load12_running", 32'(running), 32'd1);
    wait_expired(200, lat);
    check("expire_latency_12", 32'(lat), 32'd48);
    run(10);
    check("done_hold_tens", 32'(tens), 32'd0);
    check("done_hold_ones", 32'(ones), 32'd0);

    // Borrow 20 -> 19.
    do_load(4'd2, 4'd0);
    run(TICK);
    check("borrow_tens", 32'(tens), 32'd1);
    check("borrow_ones", 32'(ones), 32'd9);

    // Pause mid-step preserves the phase.
    do_load(4'd0, 4'd5);
    run(2);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    wait_expired(200, lat);
    check("expire_latency_paused", 32'(lat + 12), 32'd30);

    // Clamp and zero load.
    do_load(4'hC, 4'hA);
    check("clamp_tens", 32'(tens), 32'd9);
    check("clamp_ones", 32'(ones), 32'd9);
    do_load(4'd0, 4'd0);
    check("zero_load_expired", 32'(expired), 32'd1);
    check("zero_load_running", 32'(running), 32'd0);
    run(3);

    // Load coinciding with a tick from 03.
    do_load(4'd0, 4'd3);
    run(TICK - 1);
    do_load(4'd0, 4'd7);
    check("load_on_tick_ones", 32'(ones), 32'd7);
    run(TICK);
    check("after_load_on_tick", 32'(ones), 32'd6);

    // Reset mid-count.
    do_load(4'd1, 4'd5);
    run(6);
    reset = 1'b1;
    tick_cycle();
    reset = 1'b0;
    check("reset_tens", 32'(tens), 32'd0);
    check("reset_expired", 32'(expired), 32'd0);
    run(10);

    // Random traffic, biased toward short loads so expiry is reached often.
    for (int i = 0; i < 800; i++) begin
      reset  = ($urandom_range(0, 149) == 0);
      load   = ($urandom_range(0, 24) == 0);
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) begin
        load_tens = 4'($urandom_range(0, 15));
        load_ones = 4'($urandom_range(0, 15));
      end else begin
        load_tens = 4'd0;
        load_ones = 4'($urandom_range(0, 4));
      end
      tick_cycle();
    end
    reset = 1'b0; load = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
